// File: rtl/vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// vga_sync_receiver
//
// Recovers pixel/line position from an incoming VGA-style h/v sync pair and
// locks onto the timing once two consecutive vertical syncs agree with the
// expected frame geometry. A pixel is consumed on each clk where pix_en=1.
//
// Parameters:
//   H_TOTAL, H_ACTIVE, H_SYNC_START : horizontal geometry (pixels)
//   V_TOTAL, V_ACTIVE, V_SYNC_START : vertical geometry (lines)
//
// Ports:
//   clk            in   system clock, all flops on rising edge
//   reset          in   synchronous active-high reset
//   pix_en         in   pixel strobe
//   vga_h_sync_in  in   horizontal sync, active-low
//   vga_v_sync_in  in   vertical sync, active-low
//   RxCounterX     out  recovered pixel x (one pix_en behind the pins)
//   RxCounterY     out  recovered line y
//   rxDisplayArea  out  locked and inside the visible window
//   locked         out  FSM is in LOCKED
//   sync_err       out  one-clk pulse on a timing violation
//   frame_count    out  complete locked frames, modulo 256
//
// Optional feature: define VGA_RX_FRAMECNT_EN to build the frame counter;
// otherwise frame_count is tied to 0.
// -----------------------------------------------------------------------------
module vga_sync_receiver #(
  parameter int H_TOTAL      = 800,
  parameter int H_ACTIVE     = 640,
  parameter int H_SYNC_START = 656,
  parameter int V_TOTAL      = 525,
  parameter int V_ACTIVE     = 480,
  parameter int V_SYNC_START = 490
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_en,
  input  logic       vga_h_sync_in,
  input  logic       vga_v_sync_in,
  output logic [9:0] RxCounterX,
  output logic [9:0] RxCounterY,
  output logic       rxDisplayArea,
  output logic       locked,
  output logic       sync_err,
  output logic [7:0] frame_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'b00,
    TRACK  = 2'b01,
    LOCKED = 2'b10
  } state_e;

  localparam int MW = (H_TOTAL > 2) ? $clog2(H_TOTAL) : 1;

  localparam logic [9:0]    X_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]    Y_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]    X_SYNC    = 10'(H_SYNC_START);
  localparam logic [9:0]    Y_SYNC    = 10'(V_SYNC_START);
  localparam logic [9:0]    X_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]    Y_ACT     = 10'(V_ACTIVE);
  localparam logic [MW-1:0] MISS_LAST = MW'(H_TOTAL - 1);

  state_e        state_q, state_d;
  logic          h_prev_q, h_prev_d;
  logic          v_prev_q, v_prev_d;
  logic [9:0]    x_q, x_d;
  logic [9:0]    y_q, y_d;
  logic [MW-1:0] miss_q, miss_d;      // consecutive pixels without an h edge
  logic          mism_q, mism_d;      // h mismatch seen during TRACK
  logic          locked_q, locked_d;
  logic          disp_q, disp_d;
  logic          err_q, err_d;

  logic       h_edge, v_edge;
  logic       x_wrap;
  logic [9:0] x_adv, y_adv;
  logic       h_bad, v_bad, miss_hit;

  // Leading edge: registered previous sample high, current pin low.
  assign h_edge = h_prev_q & ~vga_h_sync_in;
  assign v_edge = v_prev_q & ~vga_v_sync_in;

  // Free-running prediction of the position of the pixel now on the pins.
  assign x_wrap = (x_q == X_LAST);
  assign x_adv  = x_wrap ? 10'd0 : x_q + 10'd1;
  assign y_adv  = !x_wrap ? y_q : ((y_q == Y_LAST) ? 10'd0 : y_q + 10'd1);

  assign h_bad    = h_edge && (x_adv != X_SYNC);
  assign v_bad    = v_edge && (y_adv != Y_SYNC);
  // Without an edge on this pixel the run reaches H_TOTAL exactly when the
  // counter already holds H_TOTAL-1.
  assign miss_hit = !h_edge && (miss_q == MISS_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    h_prev_d = h_prev_q;
    v_prev_d = v_prev_q;
    x_d      = x_q;
    y_d      = y_q;
    miss_d   = miss_q;
    mism_d   = mism_q;
    locked_d = locked_q;
    disp_d   = disp_q;
    err_d    = 1'b0;   // pulse output: never held across idle clocks

    if (pix_en) begin
      h_prev_d = vga_h_sync_in;
      v_prev_d = vga_v_sync_in;
      x_d      = x_adv;
      y_d      = y_adv;
      miss_d   = h_edge ? '0 : ((miss_q == MISS_LAST) ? miss_q : miss_q + MW'(1));

      unique case (state_q)
        SEARCH: begin
          if (h_edge) x_d = X_SYNC;
          if (v_edge) begin
            y_d     = Y_SYNC;
            state_d = TRACK;
            mism_d  = 1'b0;
          end
        end
        TRACK: begin
          if (h_edge) x_d = X_SYNC;
          if (h_bad) mism_d = 1'b1;
          if (v_edge) begin
            if (!mism_q && !h_bad && !v_bad) begin
              state_d = LOCKED;
            end else begin
              state_d = SEARCH;
              err_d   = 1'b1;
            end
          end
        end
        LOCKED: begin
          // v check first; any single violation yields exactly one pulse.
          if (v_bad) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end else if (h_bad || miss_hit) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase

      locked_d = (state_d == LOCKED);
      disp_d   = (state_d == LOCKED) && (x_d < X_ACT) && (y_d < Y_ACT);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= SEARCH;
      h_prev_q <= 1'b1;
      v_prev_q <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      miss_q   <= '0;
      mism_q   <= 1'b0;
      locked_q <= 1'b0;
      disp_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      h_prev_q <= h_prev_d;
      v_prev_q <= v_prev_d;
      x_q      <= x_d;
      y_q      <= y_d;
      miss_q   <= miss_d;
      mism_q   <= mism_d;
      locked_q <= locked_d;
      disp_q   <= disp_d;
      err_q    <= err_d;
    end
  end

  assign RxCounterX    = x_q;
  assign RxCounterY    = y_q;
  assign rxDisplayArea = disp_q;
  assign locked        = locked_q;
  assign sync_err      = err_q;

`ifdef VGA_RX_FRAMECNT_EN
  logic [7:0] fc_q, fc_d;

  // A frame completes when y wraps from the last line while locked; losing
  // lock discards the count.
  always_comb begin
    fc_d = fc_q;
    if (pix_en) begin
      if (state_d == SEARCH)
        fc_d = 8'd0;
      else if (state_q == LOCKED && x_wrap && y_q == Y_LAST)
        fc_d = fc_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) fc_q <= 8'd0;
    else       fc_q <= fc_d;
  end

  assign frame_count = fc_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_receiver
//
// Self-checking bench for vga_sync_receiver. The DUT runs a scaled-down frame
// (20 x 10 pixels, visible 16 x 8, h low x=17..18, v low y=8..9) so that
// hundreds of frames fit in a short run; the structure matches 640x480.
// A behavioural model tracks the recovered position as a single linear pixel
// index within the frame and is compared with the DUT on every clock.
// -----------------------------------------------------------------------------
module tb_vga_sync_receiver;

  localparam int H  = 20;
  localparam int HA = 16;
  localparam int HS = 17;
  localparam int HW = 2;
  localparam int V  = 10;
  localparam int VA = 8;
  localparam int VS = 8;
  localparam int VW = 2;
  localparam int FR = H * V;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pix_en = 1'b0;
  logic       vga_h_sync_in = 1'b1;
  logic       vga_v_sync_in = 1'b1;
  logic [9:0] RxCounterX, RxCounterY;
  logic       rxDisplayArea, locked, sync_err;
  logic [7:0] frame_count;

  vga_sync_receiver #(
    .H_TOTAL(H), .H_ACTIVE(HA), .H_SYNC_START(HS),
    .V_TOTAL(V), .V_ACTIVE(VA), .V_SYNC_START(VS)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .vga_h_sync_in(vga_h_sync_in), .vga_v_sync_in(vga_v_sync_in),
    .RxCounterX(RxCounterX), .RxCounterY(RxCounterY),
    .rxDisplayArea(rxDisplayArea), .locked(locked),
    .sync_err(sync_err), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_pulses = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- source (video generator) ----------------
  int sx = 0, sy = 0;
  int short_y = -1;   // line to emit with H-1 pixels
  int hblock = 0;     // pixels for which h stays high

  function automatic bit src_h();
    return !((sx >= HS) && (sx < HS + HW) && (hblock == 0));
  endfunction

  function automatic bit src_v();
    return !((sy >= VS) && (sy < VS + VW));
  endfunction

  task automatic src_advance();
    int len;
    if (hblock > 0) hblock--;
    len = (sy == short_y) ? H - 1 : H;
    sx++;
    if (sx >= len) begin
      if (sy == short_y) short_y = -1;
      sx = 0;
      sy = (sy + 1) % V;
    end
  endtask

  // ---------------- behavioural model ----------------
  // Position is a linear index p = y*H + x; phase 0/1/2 = hunting/checking/locked.
  int m_p, m_phase, m_fc, m_t, m_last_h;
  bit m_hp, m_vp, m_bad, m_err;
  int ex, ey, efc;
  bit elock, edisp, eerr;

  task automatic model_step(input bit pe, input bit rst, input bit h, input bit v);
    int np, px, py, prev;
    bit he, ve, hbad, vbad;
    if (rst) begin
      m_p = 0; m_phase = 0; m_fc = 0; m_t = 0; m_last_h = 0;
      m_hp = 1; m_vp = 1; m_bad = 0; m_err = 0;
    end else begin
      m_err = 0;
      if (pe) begin
        he = m_hp && !h;
        ve = m_vp && !v;
        m_hp = h;
        m_vp = v;
        m_t++;
        if (he) m_last_h = m_t;
        np = (m_p + 1) % FR;
        px = np % H;
        py = np / H;
        hbad = he && (px != HS);
        vbad = ve && (py != VS);
        prev = m_phase;
        case (m_phase)
          0: begin
            if (he) px = HS;
            if (ve) begin py = VS; m_phase = 1; m_bad = 0; end
          end
          1: begin
            if (hbad) m_bad = 1;
            if (he) px = HS;
            if (ve) begin
              if (!m_bad && !vbad) m_phase = 2;
              else begin m_phase = 0; m_err = 1; end
            end
          end
          default: begin
            if (vbad || hbad || (m_t - m_last_h) >= H) begin
              m_err = 1;
              m_phase = 0;
            end
          end
        endcase
        if (m_phase == 0) m_fc = 0;
        else if (prev == 2 && m_p == FR - 1) m_fc = (m_fc + 1) % 256;
        m_p = py * H + px;
      end
    end
    ex    = m_p % H;
    ey    = m_p / H;
    elock = (m_phase == 2);
    edisp = elock && (ex < HA) && (ey < VA);
    eerr  = m_err;
`ifdef VGA_RX_FRAMECNT_EN
    efc = m_fc;
`else
    efc = 0;
`endif
  endtask

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("RxCounterX", 32'(RxCounterX), 32'(ex));
      check("RxCounterY", 32'(RxCounterY), 32'(ey));
      check("locked", 32'(locked), 32'(elock));
      check("rxDisplayArea", 32'(rxDisplayArea), 32'(edisp));
      check("sync_err", 32'(sync_err), 32'(eerr));
      check("frame_count", 32'(frame_count), 32'(efc));
      if (sync_err) err_pulses++;
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input bit pe, input bit rst);
    bit h, v;
    @(negedge clk);
    #1;
    h = src_h();
    v = src_v();
    reset = rst;
    pix_en = pe;
    vga_h_sync_in = h;
    vga_v_sync_in = v;
    @(posedge clk);
    model_step(pe, rst, h, v);
    if (pe && !rst) src_advance();
    #1;
  endtask

  task automatic do_reset(input int sx0, input int sy0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    sx = sx0; sy = sy0; short_y = -1; hblock = 0;
    chk_en = 1'b1;
  endtask

  task automatic run_until_locked(input int period, output int strobes);
    strobes = 0;
    for (int i = 0; i < 4000; i++) begin
      tick(((i % period) == 0), 1'b0);
      if ((i % period) == 0) strobes++;
      if (locked) break;
    end
    check("lock_timeout", 32'(locked), 32'd1);
  endtask

  task automatic run_to(input int tx, input int ty);
    for (int i = 0; i < 2 * FR; i++) begin
      if (sx == tx && sy == ty) break;
      tick(1'b1, 1'b0);
    end
    check("run_to_timeout", 32'((sx == tx) && (sy == ty)), 32'd1);
  endtask

  initial begin
    int n, e0;

    // Reset state.
    do_reset(0, 0);
    check("rst_x", 32'(RxCounterX), 32'd0);
    check("rst_y", 32'(RxCounterY), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_disp", 32'(rxDisplayArea), 32'd0);
    check("rst_err", 32'(sync_err), 32'd0);
    check("rst_fc", 32'(frame_count), 32'd0);

    // Continuous strobe: lock one strobe after the second v edge (pixel 360).
    e0 = err_pulses;
    run_until_locked(1, n);
    check("lock_point_cont", 32'(n), 32'd361);
    check("no_err_to_lock", 32'(err_pulses - e0), 32'd0);

    // Visible-window checks on a locked stream.
    run_to(0, 0);
    tick(1'b1, 1'b0);
    check("x_at_origin", 32'(RxCounterX), 32'd0);
    check("y_at_origin", 32'(RxCounterY), 32'd0);
    check("disp_at_origin", 32'(rxDisplayArea), 32'd1);
    run_to(HA, 0);
    tick(1'b1, 1'b0);
    check("disp_at_x_active", 32'(rxDisplayArea), 32'd0);

    // One line one pixel short: error at the next h edge.
    run_to(0, 2);
    short_y = 3;
    e0 = err_pulses;
    run_to(HS, 4);
    tick(1'b1, 1'b0);
    check("short_line_err", 32'(sync_err), 32'd1);
    check("short_line_unlock", 32'(locked), 32'd0);
    check("short_line_search", 32'(dut.state_q), 32'd0);
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0);
    check("short_line_one_pulse", 32'(err_pulses - e0), 32'd1);

    // Relock, then suppress one h pulse: missing-edge error.
    run_until_locked(1, n);
    run_to(0, 2);
    e0 = err_pulses;
    hblock = H;
    for (int i = 0; i < 60; i++) tick(1'b1, 1'b0);
    check("missing_h_one_pulse", 32'(err_pulses - e0), 32'd1);
    check("missing_h_unlock", 32'(locked), 32'd0);

    // Strobe every fourth clock: same lock point counted in strobes.
    do_reset(0, 0);
    run_until_locked(4, n);
    check("lock_point_div4", 32'(n), 32'd361);

    // Randomized strobe pattern, start phase and timing faults.
    do_reset($urandom_range(0, H - 1), $urandom_range(0, V - 1));
    for (int i = 0; i < 3000; i++) begin
      if (i == 900 || i == 2100) short_y = $urandom_range(0, V - 1);
      if (i == 1500) hblock = H + $urandom_range(0, 5);
      tick(($urandom_range(0, 2) != 0), 1'b0);
    end

    // 260 locked frames, then reset mid-frame.
    do_reset(0, 0);
    run_until_locked(1, n);
    for (int i = 0; i < 260 * FR; i++) tick(1'b1, 1'b0);
`ifdef VGA_RX_FRAMECNT_EN
    check("frame_count_260", 32'(frame_count), 32'd4);
`else
    check("frame_count_off", 32'(frame_count), 32'd0);
`endif
    check("still_locked", 32'(locked), 32'd1);
    run_to(3, 5);
    e0 = err_pulses;
    tick(1'b1, 1'b1);
    check("midrst_x", 32'(RxCounterX), 32'd0);
    check("midrst_y", 32'(RxCounterY), 32'd0);
    check("midrst_locked", 32'(locked), 32'd0);
    check("midrst_disp", 32'(rxDisplayArea), 32'd0);
    check("midrst_err", 32'(sync_err), 32'd0);
    check("midrst_fc", 32'(frame_count), 32'd0);
    tick(1'b0, 1'b0);
    check("midrst_no_pulse", 32'(err_pulses - e0), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
